marine_radar_trigger_gate: RTL and testbench

- Consumes the trigger and capture settings produced by the master control block: trig_thresh_excite/relax, trig_latency, trig_delay, n_samples and enable_rx.
- Detects radar trigger pulses on the digitized trigger channel using a hysteresis comparator.
- After each detected trigger, waits trig_delay samples, then gates exactly n_samples video samples to the downstream packer.
- Sits between the decimated sample stream and the RX packer, clocked on master_clk.

---
 rtl/marine_radar_trigger_gate_pkg.sv | 22 ++
 rtl/marine_radar_hyst_detect.sv | 83 ++++++++
 rtl/marine_radar_trigger_gate.sv | 175 +++++++++++++++++
 tb/tb_marine_radar_trigger_gate.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/marine_radar_trigger_gate_pkg.sv
// Shared encodings and constants for the marine radar trigger gate.
package marine_radar_trigger_gate_pkg;

    typedef enum logic [1:0] {
        GATE_IDLE    = 2'd0,
        GATE_DELAY   = 2'd1,
        GATE_CAPTURE = 2'd2
    } gate_state_t;

    typedef enum logic {
        DET_RELAXED = 1'b0,
        DET_EXCITED = 1'b1
    } det_state_t;

    localparam logic [15:0] MISSED_SAT = 16'hFFFF;

    // Saturating increment used for the missed-trigger counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == MISSED_SAT) ? value : (value + 16'd1);
    endfunction

endpackage

// File: rtl/marine_radar_hyst_detect.sv
// Hysteresis trigger detector: fires once a run of samples at or above the
// excite threshold reaches the latency length, then re-arms only after a
// sample falls below the relax threshold. Also used for 1-bit ARP/ACP channels.
module marine_radar_hyst_detect
    import marine_radar_trigger_gate_pkg::*;
#(
    parameter int DW = 12,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_strobe,
    input  logic [DW-1:0] i_sample,
    input  logic [DW-1:0] i_excite,
    input  logic [DW-1:0] i_relax,
    input  logic [CW-1:0] i_latency,
    output logic          o_fire
);

    localparam logic [CW-1:0] ONE = CW'(1'b1);

    det_state_t    r_state;
    det_state_t    w_state_next;
    logic [CW-1:0] r_run;
    logic [CW-1:0] w_run_next;
    logic [CW-1:0] w_run_inc;
    logic [CW-1:0] w_lat_eff;

    // A latency of zero is treated as a single-sample run.
    assign w_lat_eff = (i_latency == {CW{1'b0}}) ? ONE : i_latency;
    assign w_run_inc = r_run + ONE;

    // Detector state and run counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= DET_RELAXED;
            r_run   <= {CW{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_run   <= w_run_next;
        end
    end

    // Next-state logic and fire decision, advancing only on strobe.
    always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run;
        o_fire       = 1'b0;
        if (i_clear) begin
            w_state_next = DET_RELAXED;
            w_run_next   = {CW{1'b0}};
        end else if (i_strobe) begin
            case (r_state)
                DET_RELAXED: begin
                    if (i_sample < i_excite) begin
                        w_run_next = {CW{1'b0}};
                    end else if (w_run_inc == w_lat_eff) begin
                        o_fire       = 1'b1;
                        w_state_next = DET_EXCITED;
                        w_run_next   = {CW{1'b0}};
                    end else begin
                        w_run_next = w_run_inc;
                    end
                end
                DET_EXCITED: begin
                    if (i_sample < i_relax) begin
                        w_state_next = DET_RELAXED;
                    end else begin
                        w_state_next = DET_EXCITED;
                    end
                end
                default: begin
                    w_state_next = DET_RELAXED;
                    w_run_next   = {CW{1'b0}};
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

endmodule

// File: rtl/marine_radar_trigger_gate.sv
// Radar trigger gate: detects trigger pulses and, after a programmable delay,
// gates a fixed number of video samples toward the RX packer.
module marine_radar_trigger_gate
    import marine_radar_trigger_gate_pkg::*;
#(
    parameter int DW = 12,
    parameter int CW = 16
) (
    input  logic          master_clk,
    input  logic          rx_dsp_reset,
    input  logic          enable_rx,
    input  logic          sample_strobe,
    input  logic [DW-1:0] trig_in,
    input  logic [DW-1:0] trig_thresh_excite,
    input  logic [DW-1:0] trig_thresh_relax,
    input  logic [CW-1:0] trig_latency,
    input  logic [CW-1:0] trig_delay,
    input  logic [CW-1:0] n_samples,
    input  logic          new_mode,
    output logic          trig_pulse,
    output logic          capture_en,
    output logic          capture_first,
    output logic          capture_last,
    output logic [31:0]   trig_count,
    output logic [15:0]   missed_count
);

    localparam logic [CW-1:0] ONE = CW'(1'b1);

    logic          w_fire;
    gate_state_t   r_state;
    gate_state_t   w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] r_delay;
    logic [CW-1:0] w_delay_next;
    logic [CW-1:0] r_n;
    logic [CW-1:0] w_n_next;
    logic [31:0]   r_trig_count;
    logic [31:0]   w_trig_count_next;
    logic [15:0]   r_missed;
    logic [15:0]   w_missed_next;
    logic          r_pulse;
    logic          r_cap;
    logic          r_first;
    logic          r_last;
    logic          w_pulse;
    logic          w_cap;
    logic          w_first;
    logic          w_last;

    marine_radar_hyst_detect #(.DW(DW), .CW(CW)) u_detect (
        .i_clk     (master_clk),
        .i_rst     (rx_dsp_reset),
        .i_clear   (!enable_rx),
        .i_strobe  (sample_strobe),
        .i_sample  (trig_in),
        .i_excite  (trig_thresh_excite),
        .i_relax   (trig_thresh_relax),
        .i_latency (trig_latency),
        .o_fire    (w_fire)
    );

    assign w_cnt_inc = r_cnt + ONE;

    // Gate FSM state, latched settings, counters and registered outputs.
    always_ff @(posedge master_clk) begin
        if (rx_dsp_reset) begin
            r_state      <= GATE_IDLE;
            r_cnt        <= {CW{1'b0}};
            r_delay      <= {CW{1'b0}};
            r_n          <= {CW{1'b0}};
            r_trig_count <= 32'd0;
            r_missed     <= 16'd0;
            r_pulse      <= 1'b0;
            r_cap        <= 1'b0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_delay      <= w_delay_next;
            r_n          <= w_n_next;
            r_trig_count <= w_trig_count_next;
            r_missed     <= w_missed_next;
            r_pulse      <= w_pulse;
            r_cap        <= w_cap;
            r_first      <= w_first;
            r_last       <= w_last;
        end
    end

    // Gate FSM next state and output decode; new_mode overrides a same-cycle fire.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_delay_next      = r_delay;
        w_n_next          = r_n;
        w_trig_count_next = r_trig_count;
        w_missed_next     = r_missed;
        w_pulse           = 1'b0;
        w_cap             = 1'b0;
        w_first           = 1'b0;
        w_last            = 1'b0;
        if (!enable_rx || new_mode) begin
            w_state_next = GATE_IDLE;
            w_cnt_next   = {CW{1'b0}};
        end else if (sample_strobe) begin
            case (r_state)
                GATE_IDLE: begin
                    if (w_fire) begin
                        w_pulse           = 1'b1;
                        w_trig_count_next = r_trig_count + 32'd1;
                        w_delay_next      = trig_delay;
                        w_n_next          = n_samples;
                        w_cnt_next        = {CW{1'b0}};
                        if (n_samples == {CW{1'b0}}) begin
                            w_state_next = GATE_IDLE;
                        end else if (trig_delay == {CW{1'b0}}) begin
                            w_state_next = GATE_CAPTURE;
                        end else begin
                            w_state_next = GATE_DELAY;
                        end
                    end else begin
                        w_state_next = GATE_IDLE;
                    end
                end
                GATE_DELAY: begin
                    if (w_fire) begin
                        w_missed_next = sat_inc16(r_missed);
                    end else begin
                        w_missed_next = r_missed;
                    end
                    if (w_cnt_inc == r_delay) begin
                        w_state_next = GATE_CAPTURE;
                        w_cnt_next   = {CW{1'b0}};
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                GATE_CAPTURE: begin
                    if (w_fire) begin
                        w_missed_next = sat_inc16(r_missed);
                    end else begin
                        w_missed_next = r_missed;
                    end
                    w_cap   = 1'b1;
                    w_first = (r_cnt == {CW{1'b0}});
                    w_last  = (w_cnt_inc == r_n);
                    if (w_cnt_inc == r_n) begin
                        w_state_next = GATE_IDLE;
                        w_cnt_next   = {CW{1'b0}};
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_next = GATE_IDLE;
                    w_cnt_next   = {CW{1'b0}};
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    assign trig_pulse    = r_pulse;
    assign capture_en    = r_cap;
    assign capture_first = r_first;
    assign capture_last  = r_last;
    assign trig_count    = r_trig_count;
    assign missed_count  = r_missed;

endmodule

// File: tb/tb_marine_radar_trigger_gate.sv
// Directed bench for marine_radar_trigger_gate with an expected-output queue.
module tb_marine_radar_trigger_gate;

    logic        master_clk = 1'b0;
    logic        rx_dsp_reset = 1'b1;
    logic        enable_rx = 1'b0;
    logic        sample_strobe = 1'b0;
    logic [11:0] trig_in = 12'd0;
    logic [11:0] trig_thresh_excite = 12'd2000;
    logic [11:0] trig_thresh_relax = 12'd1000;
    logic [15:0] trig_latency = 16'd3;
    logic [15:0] trig_delay = 16'd5;
    logic [15:0] n_samples = 16'd4;
    logic        new_mode = 1'b0;
    logic        trig_pulse;
    logic        capture_en;
    logic        capture_first;
    logic        capture_last;
    logic [31:0] trig_count;
    logic [15:0] missed_count;

    int checks = 0;
    int errors = 0;
    int cap_seen = 0;
    logic [3:0] exp_q[$];

    // Expected-output encodings: {trig_pulse, capture_en, capture_first, capture_last}
    localparam logic [3:0] E_NONE  = 4'b0000;
    localparam logic [3:0] E_PULSE = 4'b1000;

    marine_radar_trigger_gate #(.DW(12), .CW(16)) dut (
        .master_clk         (master_clk),
        .rx_dsp_reset       (rx_dsp_reset),
        .enable_rx          (enable_rx),
        .sample_strobe      (sample_strobe),
        .trig_in            (trig_in),
        .trig_thresh_excite (trig_thresh_excite),
        .trig_thresh_relax  (trig_thresh_relax),
        .trig_latency       (trig_latency),
        .trig_delay         (trig_delay),
        .n_samples          (n_samples),
        .new_mode           (new_mode),
        .trig_pulse         (trig_pulse),
        .capture_en         (capture_en),
        .capture_first      (capture_first),
        .capture_last       (capture_last),
        .trig_count         (trig_count),
        .missed_count       (missed_count)
    );

    always #5 master_clk = ~master_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {trig_pulse, capture_en, capture_first, capture_last};
    endfunction

    // One strobe: outputs must be quiet beforehand, then match the queued expectation.
    task automatic step(input logic [11:0] t, input logic [3:0] exp, input logic nm = 1'b0);
        logic [3:0] want;
        @(negedge master_clk);
        check("quiet", {28'd0, outs()}, 32'd0);
        sample_strobe = 1'b1;
        trig_in       = t;
        new_mode      = nm;
        exp_q.push_back(exp);
        @(negedge master_clk);
        sample_strobe = 1'b0;
        new_mode      = 1'b0;
        want = exp_q.pop_front();
        if (capture_en === 1'b1) cap_seen++;
        check("strobe_out", {28'd0, outs()}, {28'd0, want});
    endtask

    // Capture window of n strobes at constant trigger level.
    task automatic capture_run(input int n, input logic [11:0] t);
        for (int i = 1; i <= n; i++) begin
            step(t, {1'b0, 1'b1, (i == 1), (i == n)});
        end
    endtask

    initial begin
        repeat (3) @(posedge master_clk);
        @(negedge master_clk);
        check("rst_pulse", {31'd0, trig_pulse}, 32'd0);
        check("rst_cap", {29'd0, capture_en, capture_first, capture_last}, 32'd0);
        check("rst_tcount", trig_count, 32'd0);
        check("rst_missed", {16'd0, missed_count}, 32'd0);
        rx_dsp_reset = 1'b0;
        enable_rx    = 1'b1;

        // Basic trigger: fire on strobe 3, captures on strobes 9..12.
        step(12'd2500, E_NONE);
        step(12'd2500, E_NONE);
        step(12'd2500, E_PULSE);
        repeat (5) step(12'd2500, E_NONE);
        capture_run(4, 12'd2500);
        check("basic_tcount", trig_count, 32'd1);

        // Hysteresis: mid-band samples never re-fire; below relax re-arms.
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 12'd1500 : 12'd2500, E_NONE);
        step(12'd900, E_NONE);
        step(12'd2500, E_NONE);
        step(12'd2500, E_NONE);
        step(12'd2500, E_PULSE);
        repeat (5) step(12'd1500, E_NONE);
        capture_run(4, 12'd1500);
        check("hyst_tcount", trig_count, 32'd2);
        step(12'd900, E_NONE);

        // Latency reset with n=0: only the 6th strobe fires, nothing captured.
        n_samples = 16'd0;
        step(12'd2500, E_NONE);
        step(12'd2500, E_NONE);
        step(12'd1500, E_NONE);
        step(12'd2500, E_NONE);
        step(12'd2500, E_NONE);
        step(12'd2500, E_PULSE);
        repeat (8) step(12'd1500, E_NONE);
        check("n0_tcount", trig_count, 32'd3);
        step(12'd900, E_NONE);

        // latency=0, delay=0, n=1: immediate fire, first+last on next strobe.
        trig_latency = 16'd0;
        trig_delay   = 16'd0;
        n_samples    = 16'd1;
        step(12'd2500, E_PULSE);
        step(12'd2500, 4'b0111);
        step(12'd900, E_NONE);
        check("n1_tcount", trig_count, 32'd4);

        // Busy: second fire at capture sample 50 is counted as missed.
        trig_latency = 16'd1;
        n_samples    = 16'd100;
        step(12'd2500, E_PULSE);
        cap_seen = 0;
        for (int i = 1; i <= 100; i++) begin
            step((i == 49) ? 12'd900 : 12'd2500, {1'b0, 1'b1, (i == 1), (i == 100)});
        end
        check("busy_capcount", cap_seen, 32'd100);
        step(12'd2500, E_NONE);
        check("busy_missed", {16'd0, missed_count}, 32'd1);
        check("busy_tcount", trig_count, 32'd5);
        step(12'd900, E_NONE);

        // Abort after capture sample 10, then a full 50-sample capture.
        n_samples = 16'd50;
        step(12'd2500, E_PULSE);
        for (int i = 1; i <= 10; i++) begin
            step(12'd2500, {1'b0, 1'b1, (i == 1), 1'b0});
        end
        @(negedge master_clk);
        new_mode = 1'b1;
        @(negedge master_clk);
        new_mode = 1'b0;
        step(12'd2500, E_NONE);
        step(12'd900, E_NONE);
        step(12'd2500, E_PULSE);
        cap_seen = 0;
        capture_run(50, 12'd2500);
        check("abort_full50", cap_seen, 32'd50);
        step(12'd2500, E_NONE);
        check("abort_tcount", trig_count, 32'd7);

        // new_mode coincident with a fire: trigger dropped, no capture follows.
        step(12'd900, E_NONE);
        step(12'd2500, E_NONE, 1'b1);
        step(12'd2500, E_NONE);
        check("nm_fire_tcount", trig_count, 32'd7);
        check("nm_fire_missed", {16'd0, missed_count}, 32'd1);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
